// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate-model BIST sequencer.
// Holds the FSM state type, the LFSR/MISR feedback tap masks, default
// seeds and the legal settle-time range.
package gate_bist_pkg;

    localparam int unsigned N_IN_DEF   = 20;
    localparam int unsigned N_OUT_DEF  = 10;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned SETTLE_DEF = 2;

    // Settle counter is sized for the largest legal hold time
    localparam int unsigned SETTLE_MIN = 1;
    localparam int unsigned SETTLE_MAX = 15;
    localparam int unsigned SETTLE_W   = 4;

    // Feedback tap masks: x^20+x^17+1 (bits 19,16) and x^10+x^7+1 (bits 9,6)
    localparam logic [N_IN_DEF-1:0]  LFSR_TAPS = 20'h9_0000;
    localparam logic [N_OUT_DEF-1:0] MISR_TAPS = 10'h240;

    localparam logic [N_IN_DEF-1:0]  LFSR_SEED_DEF = 20'h0_0001;
    localparam logic [N_OUT_DEF-1:0] MISR_SEED_DEF = 10'h001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_APPLY,
        ST_CAPTURE,
        ST_DONE
    } bist_state_t;

endpackage

// File: rtl/gate_bist_lfsr.sv
// Fibonacci shift register used both as the pattern LFSR and as the MISR.
//   clk, rst_n  : clock, async active-low reset (register clears to 0)
//   load_i      : load seed_i (takes priority over shift_i)
//   seed_i      : seed value; in LFSR mode a zero seed is forced to 1
//   shift_i     : advance one step
//   din_i       : parallel data folded in on each shift (MISR mode only)
//   state_o     : current register value
//   nxt_c       : combinational value the register takes at the next edge
module gate_bist_lfsr #(
    parameter int unsigned      WIDTH     = 20,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(1),
    parameter bit               MISR_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] state_o,
    output logic [WIDTH-1:0] nxt_c
);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] seed_m, din_m;
    logic             fb;

    // Next-state: load, shift with feedback (plus data in MISR mode), or hold
    always_comb begin
        fb      = ^(state_q & TAPS);
        din_m   = din_i & {WIDTH{MISR_MODE}};
        seed_m  = seed_i;
        state_d = state_q;
        // An all-zero LFSR would lock up, so never load one
        if (!MISR_MODE && (seed_i == '0)) begin
            seed_m = WIDTH'(1);
        end
        if (load_i) begin
            state_d = seed_m;
        end else if (shift_i) begin
            state_d = {state_q[WIDTH-2:0], fb} ^ din_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;
    assign nxt_c   = state_d;

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer for the 20-in / 10-out combinational gate models.
// Applies LFSR patterns, holds each for SETTLE cycles, compacts the model
// outputs into a MISR and compares the final signature to a golden value.
//   clk, rst_n : clock, async active-low reset
//   start      : begin a run (accepted in IDLE or DONE only)
//   abort      : return to IDLE from any state (beats start)
//   pat_count  : number of patterns, latched on start
//   golden_sig : expected signature, latched on start
//   dut_in     : pattern driven to the gate model
//   dut_out    : gate model response
//   busy       : run in progress (LOAD/APPLY/CAPTURE)
//   done       : run finished; pass is valid while high
//   pass       : signature matched golden
//   signature  : current MISR value
//   pat_idx    : index of the pattern being applied
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int unsigned       N_IN      = N_IN_DEF,
    parameter int unsigned       N_OUT     = N_OUT_DEF,
    parameter int unsigned       SETTLE    = SETTLE_DEF,
    parameter int unsigned       CNT_W     = CNT_W_DEF,
    parameter logic [N_IN-1:0]   LFSR_SEED = N_IN'(LFSR_SEED_DEF),
    parameter logic [N_OUT-1:0]  MISR_SEED = N_OUT'(MISR_SEED_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] pat_count,
    input  logic [N_OUT-1:0] golden_sig,
    output logic [N_IN-1:0]  dut_in,
    input  logic [N_OUT-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_OUT-1:0] signature,
    output logic [CNT_W-1:0] pat_idx
);

    bist_state_t          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     idx_q, idx_d;
    logic [N_OUT-1:0]     gold_q, gold_d;
    logic [SETTLE_W-1:0]  settle_q, settle_d;
    logic [N_IN-1:0]      dut_in_q, dut_in_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;

    logic                 seq_load, seq_shift;
    logic                 last_pat;
    logic [N_IN-1:0]      lfsr_nxt, lfsr_state_unused;
    logic [N_OUT-1:0]     misr_q, misr_nxt;

    // Pattern generator; its next value is what the model sees on entry to APPLY
    gate_bist_lfsr #(
        .WIDTH     (N_IN),
        .TAPS      (N_IN'(LFSR_TAPS)),
        .MISR_MODE (1'b0)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (seq_load),
        .seed_i  (LFSR_SEED),
        .shift_i (seq_shift),
        .din_i   ('0),
        .state_o (lfsr_state_unused),
        .nxt_c   (lfsr_nxt)
    );

    // Response compactor
    gate_bist_lfsr #(
        .WIDTH     (N_OUT),
        .TAPS      (N_OUT'(MISR_TAPS)),
        .MISR_MODE (1'b1)
    ) u_misr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (seq_load),
        .seed_i  (MISR_SEED),
        .shift_i (seq_shift),
        .din_i   (dut_out),
        .state_o (misr_q),
        .nxt_c   (misr_nxt)
    );

    // Full-width compare; cnt_q is nonzero whenever this is consulted
    assign last_pat = (idx_q == (cnt_q - CNT_W'(1)));

    // Next-state and counter control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gold_d    = gold_q;
        idx_d     = idx_q;
        settle_d  = settle_q;
        seq_load  = 1'b0;
        seq_shift = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    cnt_d   = pat_count;
                    gold_d  = golden_sig;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                seq_load = 1'b1;
                idx_d    = '0;
                settle_d = '0;
                state_d  = (cnt_q == '0) ? ST_DONE : ST_APPLY;
            end
            ST_APPLY: begin
                if (settle_q == SETTLE_W'(SETTLE - 1)) begin
                    settle_d = '0;
                    state_d  = ST_CAPTURE;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            ST_CAPTURE: begin
                seq_shift = 1'b1;
                if (last_pat) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + CNT_W'(1);
                    state_d = ST_APPLY;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort freezes everything (including the MISR) and forces IDLE
        if (abort) begin
            state_d   = ST_IDLE;
            cnt_d     = cnt_q;
            gold_d    = gold_q;
            idx_d     = idx_q;
            settle_d  = settle_q;
            seq_load  = 1'b0;
            seq_shift = 1'b0;
        end
    end

    // Registered outputs decoded from the next state
    always_comb begin
        busy_d   = (state_d == ST_LOAD) || (state_d == ST_APPLY) ||
                   (state_d == ST_CAPTURE);
        done_d   = (state_d == ST_DONE);
        // MISR does not move in DONE, so its next value is the final signature
        pass_d   = done_d && (misr_nxt == gold_q);
        dut_in_d = dut_in_q;
        if (state_d == ST_APPLY) begin
            dut_in_d = lfsr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            gold_q   <= '0;
            idx_q    <= '0;
            settle_q <= '0;
            dut_in_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gold_q   <= gold_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            dut_in_q <= dut_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign dut_in    = dut_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = misr_q;
    assign pat_idx   = idx_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Self-checking bench for gate_bist_ctrl (default parameters: SETTLE=2).
module tb_gate_bist_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] pat_count;
    logic [9:0]  golden_sig;
    logic [19:0] dut_in;
    logic [9:0]  dut_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [9:0]  signature;
    logic [15:0] pat_idx;

    logic [9:0]  dout_const;
    logic        fold_en;

    int n_total = 0;
    int n_pass  = 0;

    // Stand-in gate model: constant response, or XOR fold of the pattern
    assign dut_out = fold_en ? (dut_in[9:0] ^ dut_in[19:10]) : dout_const;

    gate_bist_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .pat_count  (pat_count),
        .golden_sig (golden_sig),
        .dut_in     (dut_in),
        .dut_out    (dut_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature),
        .pat_idx    (pat_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [9:0]  gold;
        logic [9:0]  dout;
        logic        fold;
        logic [9:0]  sig;
        logic        pass;
        int          edges;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // Pulse start and count edges (start edge included) until done rises
    task automatic run_one(input logic [15:0] pc, input logic [9:0] gold, output int edges);
        pat_count  = pc;
        golden_sig = gold;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("done_drop", 32'(done), 32'(0));
        edges = 1;
        while (!done && edges < 400) begin
            tick();
            edges++;
        end
    endtask

    initial begin
        int          e;
        logic [19:0] seen;

        // Edges to done = 2 + pat_count*(SETTLE+1)
        vecs[0] = '{16'd4,  10'h010, 10'h000, 1'b0, 10'h010, 1'b1, 14};
        vecs[1] = '{16'd1,  10'h3FD, 10'h3FF, 1'b0, 10'h3FD, 1'b1, 5};
        vecs[2] = '{16'd1,  10'h3FC, 10'h3FF, 1'b0, 10'h3FD, 1'b0, 5};
        vecs[3] = '{16'd0,  10'h001, 10'h3FF, 1'b0, 10'h001, 1'b1, 2};
        vecs[4] = '{16'd0,  10'h000, 10'h000, 1'b0, 10'h001, 1'b0, 2};
        vecs[5] = '{16'd2,  10'h005, 10'h3FF, 1'b0, 10'h005, 1'b1, 8};
        vecs[6] = '{16'd10, 10'h00D, 10'h000, 1'b1, 10'h00D, 1'b1, 32};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        pat_count = '0; golden_sig = '0; dout_const = '0; fold_en = 1'b0;
        tick(); tick();
        chk("rst_dut_in",    32'(dut_in),    32'(0));
        chk("rst_busy",      32'(busy),      32'(0));
        chk("rst_done",      32'(done),      32'(0));
        chk("rst_pass",      32'(pass),      32'(0));
        chk("rst_signature", 32'(signature), 32'(0));
        chk("rst_pat_idx",   32'(pat_idx),   32'(0));
        rst_n = 1'b1;
        tick();

        // Zero-pattern run straight from reset: dut_in must never move
        pat_count = 16'd0; golden_sig = 10'h001; dout_const = 10'h3FF;
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = dut_in;
        tick();
        seen = seen | dut_in;
        chk("zero_done",      32'(done),      32'(1));
        chk("zero_dut_in",    32'(seen),      32'(0));
        chk("zero_signature", 32'(signature), 32'(10'h001));
        chk("zero_pass",      32'(pass),      32'(1));

        // Four-pattern timing and pattern sequence
        pat_count = 16'd4; golden_sig = 10'h010; dout_const = 10'h000;
        start = 1'b1;
        tick();                                   // edge k
        start = 1'b0;
        tick();                                   // k+1
        chk("seq_busy",   32'(busy),    32'(1));
        chk("seq_in_0",   32'(dut_in),  32'(1));
        chk("seq_idx_0",  32'(pat_idx), 32'(0));
        for (int j = 1; j < 4; j++) begin
            tick(); tick(); tick();               // k+1+3j
            chk("seq_in",  32'(dut_in),  32'(1) << j);
            chk("seq_idx", 32'(pat_idx), 32'(j));
        end
        tick(); tick();                           // k+12
        chk("seq_done_early", 32'(done), 32'(0));
        tick();                                   // k+13
        chk("seq_done",  32'(done),      32'(1));
        chk("seq_busy0", 32'(busy),      32'(0));
        chk("seq_sig",   32'(signature), 32'(10'h010));
        chk("seq_pass",  32'(pass),      32'(1));
        chk("seq_hold",  32'(dut_in),    32'(20'h00008));

        // Table-driven runs
        for (int i = 0; i < 7; i++) begin
            dout_const = vecs[i].dout;
            fold_en    = vecs[i].fold;
            run_one(vecs[i].pc, vecs[i].gold, e);
            chk("tbl_edges", 32'(e),         32'(vecs[i].edges));
            chk("tbl_sig",   32'(signature), 32'(vecs[i].sig));
            chk("tbl_pass",  32'(pass),      32'(vecs[i].pass));
            chk("tbl_busy",  32'(busy),      32'(0));
            tick();
            chk("tbl_hold",  32'(done),      32'(1));
        end

        // Abort from a passing DONE: pass clears, signature stays
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abd_done", 32'(done),      32'(0));
        chk("abd_pass", 32'(pass),      32'(0));
        chk("abd_sig",  32'(signature), 32'(10'h00D));

        // Abort (with simultaneous start) in the third APPLY of a 10-pattern run
        fold_en = 1'b1;
        pat_count = 16'd10; golden_sig = 10'h00D;
        start = 1'b1;
        tick();                                   // edge k
        start = 1'b0;
        repeat (7) tick();                        // k+7
        chk("ab_idx",  32'(pat_idx), 32'(2));
        chk("ab_busy", 32'(busy),    32'(1));
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("ab_busy0", 32'(busy),      32'(0));
        chk("ab_done0", 32'(done),      32'(0));
        chk("ab_pass0", 32'(pass),      32'(0));
        chk("ab_sig",   32'(signature), 32'(10'h004));
        tick();
        chk("ab_idle",  32'(busy),      32'(0));
        run_one(16'd10, 10'h00D, e);
        chk("ab_rerun_edges", 32'(e),         32'(32));
        chk("ab_rerun_sig",   32'(signature), 32'(10'h00D));
        chk("ab_rerun_pass",  32'(pass),      32'(1));

        // Maximum pattern count must not finish early
        fold_en = 1'b0; dout_const = 10'h000;
        pat_count = 16'hFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (37) tick();                       // k+37
        chk("max_busy", 32'(busy),    32'(1));
        chk("max_idx",  32'(pat_idx), 32'(12));
        chk("max_done", 32'(done),    32'(0));
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Start while busy is ignored, then async reset mid-CAPTURE
        pat_count = 16'd4; golden_sig = 10'h010;
        start = 1'b1;
        tick();                                   // k
        start = 1'b0;
        tick();                                   // k+1
        pat_count = 16'd1;
        start = 1'b1;
        tick();                                   // k+2
        start = 1'b0;
        tick(); tick();                           // k+4
        chk("rs_idx1", 32'(pat_idx), 32'(1));
        chk("rs_in1",  32'(dut_in),  32'(20'h00002));
        tick(); tick();                           // k+6, in CAPTURE
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_dut_in",    32'(dut_in),    32'(0));
        chk("rs_busy",      32'(busy),      32'(0));
        chk("rs_done",      32'(done),      32'(0));
        chk("rs_pass",      32'(pass),      32'(0));
        chk("rs_signature", 32'(signature), 32'(0));
        chk("rs_pat_idx",   32'(pat_idx),   32'(0));
        tick();
        rst_n = 1'b1;
        tick();
        dout_const = 10'h3FF;
        run_one(16'd1, 10'h3FD, e);
        chk("post_rst_edges", 32'(e),         32'(5));
        chk("post_rst_sig",   32'(signature), 32'(10'h3FD));
        chk("post_rst_pass",  32'(pass),      32'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
